// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU-drive and result ports of the ALU op sequencer.
interface alu_op_sequencer_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       alu_s;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, alu_result, out_ready,
        input  in_ready, alu_s, alu_a, alu_b, out_valid, out_result, out_err
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, alu_result, out_ready,
        output in_ready, alu_s, alu_a, alu_b, out_valid, out_result, out_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered ALU select/operand driver with iterated single-bit shifts.
// Define ALU_OPSEQ_OPCHK_EN to trap opcodes 10-15 as errors instead of passing them to the ALU.
module alu_op_sequencer #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    alu_op_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [3:0] NOP   = 4'hF;
    localparam logic [WIDTH-1:0] WMAX = WIDTH'(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             cap;
    logic             trap;
    logic             is_shift;
    logic [WIDTH-1:0] amt;

    assign bus.in_ready = state == IDLE;

    always_comb begin
        is_shift = bus.in_op inside {[4'd6:4'd9]};
        amt = bus.in_b >= WMAX ? WMAX : bus.in_b;
`ifdef ALU_OPSEQ_OPCHK_EN
        trap = bus.in_op > 4'd9;
`else
        trap = 1'b0;
`endif
    end

    // cap marks ops whose result comes from the ALU in EXEC; no-ops preload out_result instead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            cap            <= 1'b0;
            bus.alu_s      <= NOP;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    cap <= 1'b0;
                    if (trap) begin
                        bus.out_result <= '0;
                        bus.out_err    <= 1'b1;
                        state          <= EXEC;
                    end else if (!is_shift) begin
                        bus.alu_s <= bus.in_op;
                        bus.alu_a <= bus.in_a;
                        bus.alu_b <= bus.in_b;
                        cap       <= 1'b1;
                        state     <= EXEC;
                    end else if (amt == '0) begin
                        bus.out_result <= bus.in_a;
                        state          <= EXEC;
                    end else begin
                        bus.alu_s <= bus.in_op;
                        bus.alu_a <= bus.in_a;
                        bus.alu_b <= '0;
                        cnt       <= CW'(amt);
                        state     <= SHIFT;
                    end
                end
                EXEC: begin
                    if (cap) bus.out_result <= bus.alu_result;
                    bus.alu_s     <= NOP;
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                SHIFT: begin
                    bus.alu_a <= bus.alu_result;
                    cnt       <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bus.out_result <= bus.alu_result;
                        bus.alu_s      <= NOP;
                        bus.out_valid  <= 1'b1;
                        state          <= DONE;
                    end
                end
                default: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.out_err   <= 1'b0;
                    bus.alu_s     <= NOP;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of the sequencer against a behavioural ALU.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad = 0;

    alu_op_sequencer_if #(.WIDTH(8)) bus ();
    alu_op_sequencer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // ALU: shift codes move one bit per pass, unused codes give 0
    always_comb begin
        bus.alu_result = 8'h00;
        case (bus.alu_s)
            4'd0: bus.alu_result = bus.alu_a + bus.alu_b;
            4'd1: bus.alu_result = bus.alu_a - bus.alu_b;
            4'd2: bus.alu_result = bus.alu_a & bus.alu_b;
            4'd3: bus.alu_result = bus.alu_a | bus.alu_b;
            4'd4: bus.alu_result = ~bus.alu_a;
            4'd5: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'd6, 4'd8: bus.alu_result = {bus.alu_a[6:0], 1'b0};
            4'd7: bus.alu_result = {1'b0, bus.alu_a[7:1]};
            4'd9: bus.alu_result = {bus.alu_a[7], bus.alu_a[7:1]};
            default: bus.alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_op = 4'd0;
        bus.in_a = 8'hEE;
        bus.in_b = 8'hEE;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int lat, input logic [7:0] exp_r);
        send(op, a, b);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, bus.out_valid, 0);
            chk({tag, "_rdy_lo"}, bus.in_ready, 0);
        end
        @(negedge clk);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_result"}, bus.out_result, exp_r);
        chk({tag, "_err"}, bus.out_err, 0);
        @(negedge clk);
        chk({tag, "_rdy_back"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [7:0] held;
        logic seen;
        bus.in_valid = 1'b0;
        bus.in_op = 4'd0;
        bus.in_a = 8'h00;
        bus.in_b = 8'h00;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_alu_s", bus.alu_s, 4'hF);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_result", bus.out_result, 0);
        chk("rst_err", bus.out_err, 0);
        chk("rst_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        send(4'd0, 8'h35, 8'h0A);
        @(negedge clk);
        chk("add_alu_s", bus.alu_s, 0);
        chk("add_alu_b", bus.alu_b, 8'h0A);
        chk("add_busy", bus.out_valid, 0);
        @(negedge clk);
        chk("add_valid", bus.out_valid, 1);
        chk("add_result", bus.out_result, 8'h3F);
        chk("add_err", bus.out_err, 0);
        chk("add_alu_s_idle", bus.alu_s, 4'hF);
        @(negedge clk);
        chk("add_rdy_back", bus.in_ready, 1);

        run("sub", 4'd1, 8'h10, 8'h03, 2, 8'h0D);
        run("and", 4'd2, 8'hF0, 8'h3C, 2, 8'h30);
        run("or", 4'd3, 8'hA0, 8'h05, 2, 8'hA5);
        run("not", 4'd4, 8'h0F, 8'h77, 2, 8'hF0);
        run("xor", 4'd5, 8'hFF, 8'h0F, 2, 8'hF0);

        send(4'd6, 8'h81, 8'd3);
        @(negedge clk);
        chk("lsl_alu_s1", bus.alu_s, 6);
        chk("lsl_alu_a1", bus.alu_a, 8'h81);
        chk("lsl_alu_b", bus.alu_b, 0);
        @(negedge clk);
        chk("lsl_alu_s2", bus.alu_s, 6);
        chk("lsl_alu_a2", bus.alu_a, 8'h02);
        @(negedge clk);
        chk("lsl_alu_s3", bus.alu_s, 6);
        chk("lsl_alu_a3", bus.alu_a, 8'h04);
        chk("lsl_busy", bus.out_valid, 0);
        @(negedge clk);
        chk("lsl_valid", bus.out_valid, 1);
        chk("lsl_result", bus.out_result, 8'h08);
        chk("lsl_alu_s_idle", bus.alu_s, 4'hF);

        send(4'd9, 8'h90, 8'd12);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("asr_alu_s", bus.alu_s, 9);
            chk("asr_busy", bus.out_valid, 0);
        end
        @(negedge clk);
        chk("asr_valid", bus.out_valid, 1);
        chk("asr_result", bus.out_result, 8'hFF);
        chk("asr_alu_s_idle", bus.alu_s, 4'hF);

        send(4'd7, 8'h5A, 8'd0);
        @(negedge clk);
        chk("lsr0_alu_s", bus.alu_s, 4'hF);
        chk("lsr0_busy", bus.out_valid, 0);
        @(negedge clk);
        chk("lsr0_valid", bus.out_valid, 1);
        chk("lsr0_result", bus.out_result, 8'h5A);
        @(negedge clk);

        run("asl_sat", 4'd8, 8'hC3, 8'd200, 9, 8'h00);
        run("lsr_sat", 4'd7, 8'hFF, 8'd8, 9, 8'h00);
        run("lsr_2", 4'd7, 8'hA4, 8'd2, 3, 8'h29);

        send(4'hC, 8'h12, 8'h34);
        @(negedge clk);
`ifdef ALU_OPSEQ_OPCHK_EN
        chk("ill_alu_s1", bus.alu_s, 4'hF);
`else
        chk("ill_alu_s1", bus.alu_s, 4'hC);
`endif
        chk("ill_busy", bus.out_valid, 0);
        @(negedge clk);
        chk("ill_alu_s2", bus.alu_s, 4'hF);
        chk("ill_valid", bus.out_valid, 1);
        chk("ill_result", bus.out_result, 0);
`ifdef ALU_OPSEQ_OPCHK_EN
        chk("ill_err", bus.out_err, 1);
`else
        chk("ill_err", bus.out_err, 0);
`endif
        @(negedge clk);
        chk("ill_err_clr", bus.out_err, 0);

        bus.out_ready = 1'b0;
        send(4'd0, 8'h21, 8'h43);
        @(negedge clk);
        @(negedge clk);
        held = 8'h64;
        bus.in_valid = 1'b1;
        bus.in_op = 4'd5;
        bus.in_a = 8'hAA;
        bus.in_b = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_result", bus.out_result, held);
            chk("bp_rdy_lo", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rdy_back", bus.in_ready, 1);
        chk("bp_valid_lo", bus.out_valid, 0);

        send(4'd6, 8'h01, 8'd8);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_alu_a", bus.alu_a, 8'h02);
        rst = 1'b1;
        #1;
        chk("rstmid_alu_s", bus.alu_s, 4'hF);
        chk("rstmid_alu_a0", bus.alu_a, 0);
        chk("rstmid_valid", bus.out_valid, 0);
        chk("rstmid_result", bus.out_result, 0);
        chk("rstmid_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rstmid_no_valid", seen, 0);
        chk("rstmid_idle_s", bus.alu_s, 4'hF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
